// File: rtl/dmem_pkg.sv
// Shared definitions for the data-side memory: access codes driven by the CPU
// control unit, MMIO register offsets, STATUS bit layout and access decoding helpers.
package dmem_pkg;

    // Access codes carried on READ_WRITE
    localparam logic [3:0] RW_IDLE = 4'b0000;
    localparam logic [3:0] RW_LB   = 4'b1000;
    localparam logic [3:0] RW_LH   = 4'b1001;
    localparam logic [3:0] RW_LW   = 4'b1010;
    localparam logic [3:0] RW_LBU  = 4'b1011;
    localparam logic [3:0] RW_LHU  = 4'b1100;
    localparam logic [3:0] RW_SB   = 4'b0101;
    localparam logic [3:0] RW_SH   = 4'b0110;
    localparam logic [3:0] RW_SW   = 4'b0111;

    // MMIO register offsets inside the 4 KiB window
    localparam logic [11:0] MMIO_TXDATA = 12'h000;
    localparam logic [11:0] MMIO_STATUS = 12'h004;
    localparam logic [11:0] MMIO_CYCLES = 12'h008;

    // STATUS register layout
    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_OVF_BIT   = 2;
    localparam int STATUS_COUNT_LSB = 3;
    localparam int STATUS_COUNT_W   = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_NONE = 2'd3
    } acc_size_e;

    typedef struct packed {
        logic      is_load;
        logic      is_store;
        logic      is_signed;
        acc_size_e size;
    } acc_dec_t;

    // Unknown codes decode to "no access" so they behave exactly like IDLE.
    function automatic acc_dec_t decode_rw(input logic [3:0] rw);
        acc_dec_t d;
        d = '{1'b0, 1'b0, 1'b0, SZ_NONE};
        case (rw)
            RW_LB:   d = '{1'b1, 1'b0, 1'b1, SZ_BYTE};
            RW_LH:   d = '{1'b1, 1'b0, 1'b1, SZ_HALF};
            RW_LW:   d = '{1'b1, 1'b0, 1'b0, SZ_WORD};
            RW_LBU:  d = '{1'b1, 1'b0, 1'b0, SZ_BYTE};
            RW_LHU:  d = '{1'b1, 1'b0, 1'b0, SZ_HALF};
            RW_SB:   d = '{1'b0, 1'b1, 1'b0, SZ_BYTE};
            RW_SH:   d = '{1'b0, 1'b1, 1'b0, SZ_HALF};
            RW_SW:   d = '{1'b0, 1'b1, 1'b0, SZ_WORD};
            default: d = '{1'b0, 1'b0, 1'b0, SZ_NONE};
        endcase
        return d;
    endfunction

    // Natural alignment check for RAM accesses.
    function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] lo);
        logic bad;
        case (sz)
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_mem_subsystem_if.sv
// CPU data bus plus TX byte stream of the data memory subsystem.
// master = CPU/consumer side, slave = memory subsystem.
interface data_mem_subsystem_if;
    logic [31:0] ADDRESS;
    logic [31:0] WRITEDATA;
    logic [3:0]  READ_WRITE;
    logic [31:0] READDATA;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;
    logic        MISALIGN_ERR;

    modport master (
        output ADDRESS, WRITEDATA, READ_WRITE, TX_READY,
        input  READDATA, TX_DATA, TX_VALID, MISALIGN_ERR
    );

    modport slave (
        input  ADDRESS, WRITEDATA, READ_WRITE, TX_READY,
        output READDATA, TX_DATA, TX_VALID, MISALIGN_ERR
    );
endinterface

// File: rtl/data_mem_subsystem_tx_fifo.sv
// Synchronous byte FIFO feeding the TX stream. Head byte is held in a register
// that changes only on push-into-empty or on pop; overflow is sticky until cleared.
module tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     ready,
    input  logic                     clr_ovf,
    output logic [7:0]               head_data,
    output logic                     valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W+1)'(0);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_next_s;
    logic [PTR_W:0]   count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       head_q, head_d;
    logic             pop_s, push_ok_s, full_s, empty_s;

    // Next-state for pointers, occupancy, overflow flag and head register.
    always_comb begin
        empty_s   = (count_q == CNT_ZERO);
        full_s    = (count_q == CNT_FULL);
        pop_s     = ~empty_s & ready;
        push_ok_s = push & (~full_s | pop_s);
        rd_next_s = rd_ptr_q + PTR_ONE;
        rd_ptr_d  = pop_s ? rd_next_s : rd_ptr_q;
        wr_ptr_d  = push_ok_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;

        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (push & full_s & ~pop_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        // With one entry left the slot after the head is where a same-cycle push lands.
        if (pop_s) begin
            if (count_q > CNT_ONE) begin
                head_d = mem_q[rd_next_s];
            end else if (push_ok_s) begin
                head_d = push_data;
            end else begin
                head_d = 8'h00;
            end
        end else if (push_ok_s & empty_s) begin
            head_d = push_data;
        end else begin
            head_d = head_q;
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= CNT_ZERO;
            ovf_q    <= 1'b0;
            head_q   <= 8'h00;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            head_q   <= head_d;
        end
    end

    // Storage array; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = head_q;
    assign valid     = ~empty_s;
    assign full      = full_s;
    assign empty     = empty_s;
    assign count     = count_q;
    assign ovf       = ovf_q;
endmodule

// File: rtl/data_mem_subsystem.sv
// Data memory of the RV32I pipeline: word RAM with byte/half/word lanes and load
// extension, plus an MMIO window holding the TX FIFO, STATUS and a cycle counter.
// Loads are combinational so MEM/WB captures READDATA in the same cycle.
module data_mem_subsystem
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    data_mem_subsystem_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]      ram_q [DEPTH_WORDS];
    acc_dec_t         dec_s;
    logic             mmio_sel_s, access_s, misalign_s;
    logic [IDX_W-1:0] idx_s;
    logic [31:0]      ram_word_s, ram_load_s, mmio_load_s, readdata_s;
    logic [7:0]       byte_s;
    logic [15:0]      half_s;
    logic [31:0]      ram_wdata_s;
    logic [3:0]       ram_be_s;
    logic             ram_we_s, fifo_push_s, clr_ovf_s;
    logic [31:0]      status_s;
    logic [31:0]      cycles_q, cycles_d;
    logic             err_q, err_d;

    logic [7:0]       fifo_head_s;
    logic             fifo_valid_s, fifo_full_s, fifo_empty_s, fifo_ovf_s;
    logic [CNT_W-1:0] fifo_count_s;

    // Decode access type, target region and alignment.
    always_comb begin
        dec_s      = decode_rw(bus.READ_WRITE);
        mmio_sel_s = (bus.ADDRESS[31:12] == MMIO_BASE[31:12]);
        access_s   = dec_s.is_load | dec_s.is_store;
        idx_s      = bus.ADDRESS[IDX_W+1:2];
        if (mmio_sel_s) begin
            misalign_s = access_s & ((dec_s.size != SZ_WORD) | (bus.ADDRESS[1:0] != 2'b00));
        end else begin
            misalign_s = access_s & is_misaligned(dec_s.size, bus.ADDRESS[1:0]);
        end
    end

    // RAM lane extraction and sign/zero extension.
    always_comb begin
        ram_word_s = ram_q[idx_s];
        byte_s     = ram_word_s[{bus.ADDRESS[1:0], 3'b000} +: 8];
        half_s     = bus.ADDRESS[1] ? ram_word_s[31:16] : ram_word_s[15:0];
        case (dec_s.size)
            SZ_BYTE: ram_load_s = dec_s.is_signed ? {{24{byte_s[7]}}, byte_s} : {24'h00_0000, byte_s};
            SZ_HALF: ram_load_s = dec_s.is_signed ? {{16{half_s[15]}}, half_s} : {16'h0000, half_s};
            SZ_WORD: ram_load_s = ram_word_s;
            default: ram_load_s = 32'h0000_0000;
        endcase
    end

    // STATUS assembly and MMIO register read mux.
    always_comb begin
        status_s                                     = 32'h0000_0000;
        status_s[STATUS_FULL_BIT]                    = fifo_full_s;
        status_s[STATUS_EMPTY_BIT]                   = fifo_empty_s;
        status_s[STATUS_OVF_BIT]                     = fifo_ovf_s;
        status_s[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(fifo_count_s);
        case (bus.ADDRESS[11:0])
            MMIO_STATUS: mmio_load_s = status_s;
            MMIO_CYCLES: mmio_load_s = cycles_q;
            default:     mmio_load_s = 32'h0000_0000;
        endcase
    end

    // Load result: zero when idle, storing or misaligned.
    always_comb begin
        if (!dec_s.is_load || misalign_s) begin
            readdata_s = 32'h0000_0000;
        end else if (mmio_sel_s) begin
            readdata_s = mmio_load_s;
        end else begin
            readdata_s = ram_load_s;
        end
    end

    // Store lane enables, replicated write data and MMIO side effects.
    always_comb begin
        case (dec_s.size)
            SZ_BYTE: begin
                ram_be_s    = 4'b0001 << bus.ADDRESS[1:0];
                ram_wdata_s = {4{bus.WRITEDATA[7:0]}};
            end
            SZ_HALF: begin
                ram_be_s    = bus.ADDRESS[1] ? 4'b1100 : 4'b0011;
                ram_wdata_s = {2{bus.WRITEDATA[15:0]}};
            end
            SZ_WORD: begin
                ram_be_s    = 4'b1111;
                ram_wdata_s = bus.WRITEDATA;
            end
            default: begin
                ram_be_s    = 4'b0000;
                ram_wdata_s = 32'h0000_0000;
            end
        endcase
        // A store coinciding with reset is dropped.
        ram_we_s    = dec_s.is_store & ~mmio_sel_s & ~misalign_s & RESET;
        fifo_push_s = dec_s.is_store & mmio_sel_s & ~misalign_s & (bus.ADDRESS[11:0] == MMIO_TXDATA);
        clr_ovf_s   = dec_s.is_load & mmio_sel_s & ~misalign_s & (bus.ADDRESS[11:0] == MMIO_STATUS);
    end

    // Byte-lane RAM write; contents survive reset.
    always_ff @(posedge CLK) begin
        if (ram_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be_s[b]) begin
                    ram_q[idx_s][8*b +: 8] <= ram_wdata_s[8*b +: 8];
                end
            end
        end
    end

    // Next cycle count and sticky misalignment flag.
    always_comb begin
        cycles_d = cycles_q + 32'd1;
        err_d    = err_q | misalign_s;
    end

    // Counter and error flag registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            cycles_q <= 32'h0000_0000;
            err_q    <= 1'b0;
        end else begin
            cycles_q <= cycles_d;
            err_q    <= err_d;
        end
    end

    tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (CLK),
        .rst_n     (RESET),
        .push      (fifo_push_s),
        .push_data (bus.WRITEDATA[7:0]),
        .ready     (bus.TX_READY),
        .clr_ovf   (clr_ovf_s),
        .head_data (fifo_head_s),
        .valid     (fifo_valid_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s),
        .ovf       (fifo_ovf_s)
    );

    assign bus.READDATA     = readdata_s;
    assign bus.TX_DATA      = fifo_head_s;
    assign bus.TX_VALID     = fifo_valid_s;
    assign bus.MISALIGN_ERR = err_q;
endmodule

// File: tb/tb_data_mem_subsystem.sv
// Scoreboard bench: stimulus queues expected load results and TX bytes; a monitor
// on the falling edge compares whenever a load is presented or a TX byte is accepted.
module tb_data_mem_subsystem;
    import dmem_pkg::*;

    localparam logic [31:0] MMIO = 32'h1000_0000;

    logic clk;
    logic rst_n;

    data_mem_subsystem_if bus();

    data_mem_subsystem #(
        .DEPTH_WORDS (1024),
        .FIFO_DEPTH  (8),
        .MMIO_BASE   (MMIO)
    ) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t       rd_q[$];
    logic [7:0] tx_q[$];
    exp_t       mon_e;
    logic [7:0] mon_b;
    int         n_checks = 0;
    int         n_fail   = 0;

    function automatic logic is_load_code(input logic [3:0] c);
        return (c == RW_LB) || (c == RW_LH) || (c == RW_LW) || (c == RW_LBU) || (c == RW_LHU);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: load results and accepted TX bytes against the scoreboard queues.
    always @(negedge clk) begin
        if (is_load_code(bus.READ_WRITE)) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_load: got %h, expected no load", bus.READDATA);
            end else begin
                mon_e = rd_q.pop_front();
                check(mon_e.name, bus.READDATA, mon_e.val);
            end
        end
        if (bus.TX_VALID && bus.TX_READY) begin
            if (tx_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_tx: got %h, expected no byte", bus.TX_DATA);
            end else begin
                mon_b = tx_q.pop_front();
                check("tx_byte", {24'h0, bus.TX_DATA}, {24'h0, mon_b});
            end
        end
    end

    task automatic op(input logic [3:0] code, input logic [31:0] addr, input logic [31:0] wdata);
        bus.READ_WRITE = code;
        bus.ADDRESS    = addr;
        bus.WRITEDATA  = wdata;
        @(posedge clk);
        #1;
        bus.READ_WRITE = RW_IDLE;
    endtask

    task automatic ld(input string name, input logic [3:0] code, input logic [31:0] addr,
                      input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.val  = exp;
        rd_q.push_back(e);
        op(code, addr, 32'h0000_0000);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.ADDRESS    = 32'h0;
        bus.WRITEDATA  = 32'h0;
        bus.READ_WRITE = RW_IDLE;
        bus.TX_READY   = 1'b0;
        rst_n          = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        check("rst_tx_valid", {31'h0, bus.TX_VALID}, 32'h0);
        check("rst_tx_data", {24'h0, bus.TX_DATA}, 32'h0);
        check("rst_misalign", {31'h0, bus.MISALIGN_ERR}, 32'h0);
        check("rst_readdata_idle", bus.READDATA, 32'h0);
        ld("rst_status", RW_LW, MMIO + 32'h4, 32'h0000_0002);

        // Loads with extension
        op(RW_SW, 32'h10, 32'hDEAD_BEEF);
        ld("lb_13", RW_LB, 32'h13, 32'hFFFF_FFDE);
        ld("lbu_13", RW_LBU, 32'h13, 32'h0000_00DE);
        ld("lh_12", RW_LH, 32'h12, 32'hFFFF_DEAD);
        ld("lhu_10", RW_LHU, 32'h10, 32'h0000_BEEF);
        ld("lb_11", RW_LB, 32'h11, 32'hFFFF_FFBE);
        ld("lw_10", RW_LW, 32'h10, 32'hDEAD_BEEF);

        // Partial stores leave other lanes untouched; upper address bits alias
        op(RW_SB, 32'h11, 32'hFFFF_FF55);
        ld("sb_lw_10", RW_LW, 32'h10, 32'hDEAD_55EF);
        ld("alias_lw_1010", RW_LW, 32'h1010, 32'hDEAD_55EF);
        op(RW_SW, 32'h20, 32'h1122_3344);
        op(RW_SH, 32'h22, 32'hFFFF_ABCD);
        ld("sh_lw_20", RW_LW, 32'h20, 32'hABCD_3344);
        check("misalign_clear", {31'h0, bus.MISALIGN_ERR}, 32'h0);

        // Misaligned store and load
        op(RW_SH, 32'h21, 32'h0000_9999);
        check("misalign_set", {31'h0, bus.MISALIGN_ERR}, 32'h1);
        ld("misal_sh_no_write", RW_LW, 32'h20, 32'hABCD_3344);
        ld("misal_lw_22", RW_LW, 32'h22, 32'h0);
        idle(2);
        check("misalign_sticky", {31'h0, bus.MISALIGN_ERR}, 32'h1);

        // MMIO odd reads
        ld("mmio_txdata_rd", RW_LW, MMIO, 32'h0);
        ld("mmio_unmapped_rd", RW_LW, MMIO + 32'hC, 32'h0);
        ld("mmio_lb_status", RW_LB, MMIO + 32'h4, 32'h0);

        // Overflow: 9 pushes into 8 entries
        for (int i = 1; i <= 9; i++) begin
            op(RW_SW, MMIO, 32'hFFFF_FF00 | 32'(i));
        end
        check("ovf_tx_valid", {31'h0, bus.TX_VALID}, 32'h1);
        check("ovf_tx_head", {24'h0, bus.TX_DATA}, 32'h01);
        ld("status_full_ovf", RW_LW, MMIO + 32'h4, 32'h0000_0045);
        ld("status_ovf_clr", RW_LW, MMIO + 32'h4, 32'h0000_0041);
        for (int i = 1; i <= 8; i++) begin
            tx_q.push_back(8'(i));
        end
        bus.TX_READY = 1'b1;
        idle(8);
        bus.TX_READY = 1'b0;
        check("drain1_tx_valid", {31'h0, bus.TX_VALID}, 32'h0);
        check("drain1_left", 32'(tx_q.size()), 32'h0);

        // Push while full with a same-cycle pop
        for (int i = 0; i < 8; i++) begin
            op(RW_SW, MMIO, 32'h10 + 32'(i));
            tx_q.push_back(8'h10 + 8'(i));
        end
        tx_q.push_back(8'hAA);
        bus.TX_READY = 1'b1;
        op(RW_SW, MMIO, 32'h0000_00AA);
        bus.TX_READY = 1'b0;
        ld("status_full_pushpop", RW_LW, MMIO + 32'h4, 32'h0000_0041);
        bus.TX_READY = 1'b1;
        idle(8);
        bus.TX_READY = 1'b0;
        check("drain2_tx_valid", {31'h0, bus.TX_VALID}, 32'h0);
        check("drain2_left", 32'(tx_q.size()), 32'h0);

        // Push into empty while ready: valid rises next cycle
        bus.TX_READY = 1'b1;
        tx_q.push_back(8'h77);
        op(RW_SW, MMIO, 32'h0000_0077);
        check("empty_push_valid", {31'h0, bus.TX_VALID}, 32'h1);
        check("empty_push_head", {24'h0, bus.TX_DATA}, 32'h77);
        idle(1);
        bus.TX_READY = 1'b0;
        check("empty_push_drained", {31'h0, bus.TX_VALID}, 32'h0);

        // Reset mid-operation
        op(RW_SW, 32'h40, 32'h0BAD_BEEF);
        op(RW_SW, MMIO, 32'h0000_005A);
        op(RW_SW, MMIO, 32'h0000_005B);
        check("pre_rst_valid", {31'h0, bus.TX_VALID}, 32'h1);
        rst_n          = 1'b0;
        bus.READ_WRITE = RW_SW;
        bus.ADDRESS    = 32'h40;
        bus.WRITEDATA  = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        bus.READ_WRITE = RW_IDLE;
        check("rst2_tx_valid", {31'h0, bus.TX_VALID}, 32'h0);
        check("rst2_misalign", {31'h0, bus.MISALIGN_ERR}, 32'h0);
        ld("cycles_0", RW_LW, MMIO + 32'h8, 32'h0);
        idle(4);
        ld("cycles_5", RW_LW, MMIO + 32'h8, 32'h5);
        ld("rst2_status", RW_LW, MMIO + 32'h4, 32'h0000_0002);
        ld("rst_store_dropped", RW_LW, 32'h40, 32'h0BAD_BEEF);

        idle(2);
        check("rd_queue_empty", 32'(rd_q.size()), 32'h0);
        check("tx_queue_empty", 32'(tx_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
